phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Generates the 3-bit `phase` that drives the instruction-control decoder of the 16-bit processor.
- Phase 0 means idle or halted. Phases 1-5 are fetch, decode, execute, memory and writeback.
- Handles run/stop, single-step mode, halt on HLT and memory wait-states.
- Counts retired instructions for the front-panel display.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin execution.
- stop  in  1  single-cycle pulse; stop at the next instruction boundary.
- step_mode  in  1  1 = execute one instruction per start pulse.
- hlt  in  1  current instruction is HLT (op=11, alu_op=1111), from decode.
- mem_ready  in  1  memory access complete; 0 stretches phase 1 or 4.
- phase  out  3  current phase, 0..5.
- running  out  1  FSM in RUN.
- halted  out  1  FSM in HALT.
- p_end  out  1  combinational; 1 when phase==5 (instruction retires this cycle).
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, phase=0, running=0, halted=0, instr_count=0, stop_pend=0.
- All registers update on the rising edge of clk.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - phase=0.
  - start=1 and stop=0: next cycle state=RUN, phase=1.
  - start=1 and stop=1 together: stop wins; stay IDLE.
- RUN, phase advance:
  - 1→2→3→4→5, one clock each.
  - Phase 1 holds while mem_ready=0 (instruction fetch).
  - Phase 4 holds while mem_ready=0.
  - mem_ready is ignored in phases 2, 3 and 5.
- RUN, stop and start:
  - stop=1 in any RUN phase sets stop_pend.
  - The current instruction always completes; no mid-instruction abort.
  - start in RUN is ignored.
- RUN, phase 5 (exactly one cycle):
  - instr_count increments, wrapping 2^CNT_W-1 → 0.
  - p_end=1.
- Next state after phase 5, in priority order:
  1. hlt=1 → HALT, phase=0, halted=1.
  2. stop_pend=1, or stop=1 in this cycle, or step_mode=1 → IDLE, phase=0, stop_pend cleared.
  3. Otherwise → phase=1, stay RUN.
- HLT instructions are counted (increment happens in phase 5 before entering HALT).
- hlt is sampled only in phase 5; its value in other phases has no effect.
- HALT: phase=0, halted=1, running=0. start and stop are ignored; only rst exits.
- Output encoding: running=1 iff state==RUN; halted=1 iff state==HALT.
- Latency:
  - start → phase=1 visible one cycle later.
  - Minimum instruction length is 5 cycles.
  - Each mem_ready=0 cycle in phase 1 or 4 adds one cycle.
- Reset asserted mid-instruction: immediate return to the reset values above. No partial retire; instr_count is cleared.
- step_mode changed mid-instruction: takes effect at the next phase-5 decision only.

Decomposition:
- Shared package (processor-wide):
  - Phase constants PH_IDLE=3'd0, PH_IF=3'd1, PH_ID=3'd2, PH_EX=3'd3, PH_MEM=3'd4, PH_WB=3'd5.
  - Sequencer state encoding SEQ_IDLE, SEQ_RUN, SEQ_HALT.
- The instruction-control decoder imports the same phase constants.
- No sub-module: the FSM, phase register and counter stay in one module.

Test Plan:
1. Reset, then start pulse at cycle 0, mem_ready=1, hlt=0:
   - phase reads 1,2,3,4,5,1,2… from cycle 1.
   - instr_count=1 after the first phase 5 and 2 after the second.
2. Running; stop pulse during phase 2:
   - Instruction completes through phase 5, then phase=0, running=0.
   - instr_count increments by exactly 1.
   - A new start resumes at phase 1.
3. step_mode=1; three start pulses, each given only while idle:
   - Each yields exactly one 1→5 sequence and a return to phase 0.
   - instr_count=3.
4. mem_ready=0 for 3 cycles on entering phase 4:
   - phase stays 4 for 4 cycles total, then 5.
   - Instruction takes 8 cycles.
   - The same check with the stall in phase 1 gives the same 8-cycle result.
5. hlt=1 in phase 5:
   - phase=0, halted=1, instr_count incremented.
   - Later start pulses leave phase=0.
   - rst=0 clears halted and instr_count to 0 asynchronously, with no clock edge needed.
6. With CNT_W=4, preload 15 retirements, run one more instruction:
   - instr_count wraps to 0.
   - Simultaneous start and stop in IDLE: phase stays 0.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared processor-wide definitions: phase numbering used by the sequencer
// and the instruction-control decoder, plus the sequencer state encoding.
package phase_sequencer_pkg;

    typedef logic [2:0] phase_t;

    localparam phase_t PH_IDLE = 3'd0;
    localparam phase_t PH_IF   = 3'd1;
    localparam phase_t PH_ID   = 3'd2;
    localparam phase_t PH_EX   = 3'd3;
    localparam phase_t PH_MEM  = 3'd4;
    localparam phase_t PH_WB   = 3'd5;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_t;

    // Advance within an instruction. Fetch and memory phases wait for the
    // memory to answer; decode and execute always take a single cycle.
    // The writeback decision (retire / halt / stop) is made by the FSM.
    function automatic phase_t advance_phase(input phase_t cur, input logic mem_ready);
        phase_t nxt;
        case (cur)
            PH_IF:   nxt = mem_ready ? PH_ID : PH_IF;
            PH_ID:   nxt = PH_EX;
            PH_EX:   nxt = PH_MEM;
            PH_MEM:  nxt = mem_ready ? PH_WB : PH_MEM;
            PH_WB:   nxt = PH_IF;
            default: nxt = PH_IF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the front panel / decode logic and the
// phase sequencer. The sequencer sits on the slave side.
interface phase_sequencer_if
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             step_mode;
    logic             hlt;
    logic             mem_ready;
    phase_t           phase;
    logic             running;
    logic             halted;
    logic             p_end;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, stop, step_mode, hlt, mem_ready,
        input  phase, running, halted, p_end, instr_count
    );

    modport slave (
        input  start, stop, step_mode, hlt, mem_ready,
        output phase, running, halted, p_end, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Phase sequencer for the 16-bit processor: steps each instruction through
// fetch/decode/execute/memory/writeback, handles run/stop, single-step,
// halt and memory wait-states, and counts retired instructions.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    phase_sequencer_if.slave  bus
);

    seq_state_t       state;
    seq_state_t       state_next;
    phase_t           phase;
    phase_t           phase_next;
    logic             stop_pend;
    logic             stop_pend_next;
    logic [CNT_W-1:0] count;
    logic             retire;

    // An instruction retires in the single writeback cycle of RUN.
    assign retire = (state == SEQ_RUN) && (phase == PH_WB);

    // State, phase and pending-stop registers; reset returns straight to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEQ_IDLE;
            phase     <= PH_IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            stop_pend <= stop_pend_next;
        end
    end

    // Next-state logic: stops are deferred to the instruction boundary, and
    // the writeback cycle decides between halt, stop/step and the next fetch.
    always_comb begin
        state_next     = state;
        phase_next     = phase;
        stop_pend_next = stop_pend;
        case (state)
            SEQ_IDLE: begin
                stop_pend_next = 1'b0;
                phase_next     = PH_IDLE;
                if (bus.start && !bus.stop) begin
                    state_next = SEQ_RUN;
                    phase_next = PH_IF;
                end
            end
            SEQ_RUN: begin
                stop_pend_next = stop_pend | bus.stop;
                if (phase == PH_WB) begin
                    if (bus.hlt) begin
                        state_next     = SEQ_HALT;
                        phase_next     = PH_IDLE;
                        stop_pend_next = 1'b0;
                    end else if (stop_pend || bus.stop || bus.step_mode) begin
                        state_next     = SEQ_IDLE;
                        phase_next     = PH_IDLE;
                        stop_pend_next = 1'b0;
                    end else begin
                        phase_next = PH_IF;
                    end
                end else begin
                    phase_next = advance_phase(phase, bus.mem_ready);
                end
            end
            SEQ_HALT: begin
                phase_next     = PH_IDLE;
                stop_pend_next = 1'b0;
            end
            default: begin
                state_next     = SEQ_IDLE;
                phase_next     = PH_IDLE;
                stop_pend_next = 1'b0;
            end
        endcase
    end

    // Status outputs decoded from the state and phase registers.
    always_comb begin
        bus.phase   = phase;
        bus.running = (state == SEQ_RUN);
        bus.halted  = (state == SEQ_HALT);
        bus.p_end   = (phase == PH_WB);
    end

    // Retired-instruction counter; wraps naturally at its full width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (retire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign bus.instr_count = count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a cycle-level behavioural model
// predicts every output, a monitor compares after each rising edge. A
// 16-bit and a 4-bit counter instance share the same stimulus.
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic step_mode = 1'b0;
    logic hlt = 1'b0;
    logic mem_ready = 1'b1;

    int assert_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        int          phase;
        bit          running;
        bit          halted;
        int unsigned count;
    } exp_t;

    exp_t exp_q[$];

    int          m_phase = 0;
    bit          m_run = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_pend = 1'b0;
    int unsigned m_count = 0;

    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_W(16)) bus ();
    phase_sequencer_if #(.CNT_W(4))  bus4 ();

    assign bus.start      = start;
    assign bus.stop       = stop;
    assign bus.step_mode  = step_mode;
    assign bus.hlt        = hlt;
    assign bus.mem_ready  = mem_ready;
    assign bus4.start     = start;
    assign bus4.stop      = stop;
    assign bus4.step_mode = step_mode;
    assign bus4.hlt       = hlt;
    assign bus4.mem_ready = mem_ready;

    phase_sequencer #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    phase_sequencer #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        assert_cnt++;
        if (actual != expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one clock of the sequencer expressed as instruction
    // progress (phase number as an integer, retire count as a plain tally).
    task automatic model_step(input bit r, input bit s, input bit p, input bit sm,
                              input bit h, input bit mr);
        if (!r) begin
            m_phase = 0; m_run = 0; m_halt = 0; m_pend = 0; m_count = 0;
        end else if (m_halt) begin
            m_phase = 0;
        end else if (!m_run) begin
            if (s && !p) begin
                m_run = 1;
                m_phase = 1;
            end
        end else if (m_phase == 5) begin
            m_count++;
            if (h) begin
                m_run = 0; m_halt = 1; m_phase = 0; m_pend = 0;
            end else if (m_pend || p || sm) begin
                m_run = 0; m_phase = 0; m_pend = 0;
            end else begin
                m_phase = 1;
            end
        end else begin
            if (p) m_pend = 1;
            if (!((m_phase == 1 || m_phase == 4) && !mr)) m_phase++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction.
    task automatic apply_stimulus(input bit r, input bit s, input bit p, input bit sm,
                                  input bit h, input bit mr);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; stop = p; step_mode = sm; hlt = h; mem_ready = mr;
        model_step(r, s, p, sm, h, mr);
        e.phase = m_phase; e.running = m_run; e.halted = m_halt; e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n, input bit sm);
        for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, sm, 0, 1);
    endtask

    task automatic run_until_phase(input int ph, input bit sm);
        for (int i = 0; i < 12 && m_phase != ph; i++) apply_stimulus(1, 0, 0, sm, 0, 1);
    endtask

    task automatic check_reset_now();
        check_output("rst_phase", int'(bus.phase), 0);
        check_output("rst_running", int'(bus.running), 0);
        check_output("rst_halted", int'(bus.halted), 0);
        check_output("rst_count16", int'(bus.instr_count), 0);
        check_output("rst_count4", int'(bus4.instr_count), 0);
    endtask

    // Reset asserted between clock edges must take effect with no edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_now();
        model_step(0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compare every queued prediction just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("phase", int'(bus.phase), e.phase);
                check_output("running", int'(bus.running), int'(e.running));
                check_output("halted", int'(bus.halted), int'(e.halted));
                check_output("p_end", int'(bus.p_end), (e.phase == 5) ? 1 : 0);
                check_output("count16", int'(bus.instr_count), int'(e.count % 65536));
                check_output("count4", int'(bus4.instr_count), int'(e.count % 16));
                check_output("phase4", int'(bus4.phase), e.phase);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        int halt_cycles;
        bit sm;
        #1 rst = 1'b0;
        #1 check_reset_now();
        apply_stimulus(0, 0, 0, 0, 0, 1);
        apply_stimulus(1, 0, 0, 0, 0, 1);

        $display("[TB] free run from a start pulse");
        apply_stimulus(1, 1, 0, 0, 0, 1);
        idle_cycles(11, 0);

        $display("[TB] stop during decode, then restart");
        run_until_phase(2, 0);
        apply_stimulus(1, 0, 1, 0, 0, 1);
        idle_cycles(8, 0);
        apply_stimulus(1, 1, 0, 0, 0, 1);
        idle_cycles(3, 0);
        apply_stimulus(1, 1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 1, 0, 0, 1);
        idle_cycles(8, 0);

        $display("[TB] single-step mode");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 0, 1, 0, 1);
            idle_cycles(7, 1);
        end

        $display("[TB] memory wait-states in phases 4 and 1");
        apply_stimulus(1, 1, 0, 0, 0, 1);
        run_until_phase(4, 0);
        for (int k = 0; k < 3; k++) apply_stimulus(1, 0, 0, 0, 0, 0);
        run_until_phase(1, 0);
        for (int k = 0; k < 3; k++) apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 0, 1);
        idle_cycles(10, 0);

        $display("[TB] long run to wrap the narrow counter");
        apply_stimulus(1, 1, 0, 0, 0, 1);
        idle_cycles(100, 0);
        apply_stimulus(1, 0, 1, 0, 0, 1);
        idle_cycles(8, 0);

        $display("[TB] simultaneous start and stop while idle");
        apply_stimulus(1, 1, 1, 0, 0, 1);
        idle_cycles(3, 0);

        $display("[TB] halt instruction");
        apply_stimulus(1, 1, 0, 0, 1, 1);
        for (int k = 0; k < 6; k++) apply_stimulus(1, 0, 0, 0, 1, 1);
        apply_stimulus(1, 1, 0, 0, 0, 1);
        apply_stimulus(1, 0, 1, 0, 0, 1);
        apply_stimulus(1, 1, 0, 0, 0, 1);
        idle_cycles(3, 0);
        async_reset();

        $display("[TB] mid-instruction reset");
        apply_stimulus(1, 1, 0, 0, 0, 1);
        run_until_phase(3, 0);
        async_reset();

        $display("[TB] randomized run");
        halt_cycles = 0;
        sm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (m_halt) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                async_reset();
            end else begin
                if ($urandom_range(19) == 0) sm = ~sm;
                apply_stimulus(1,
                               $urandom_range(5) == 0,
                               $urandom_range(15) == 0,
                               sm,
                               $urandom_range(11) == 0,
                               $urandom_range(3) != 0);
            end
        end

        idle_cycles(2, 0);
        @(posedge clk);
        #2;
        check_output("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
